// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution, EX/MEM register.
// Optional macro EXEC_BRANCH_EXT_EN adds BLT/BGE/BLTU/BGEU branch conditions.
module execute_cycle #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWrite_E,
   input  logic            ALUSrc_E,
   input  logic            MemWrite_E,
   input  logic            Branch_E,
   input  logic            Jump_E,
   input  logic [1:0]      ResultSrc_E,
   input  logic [2:0]      ALUControl_E,
   input  logic [2:0]      funct3_E,
   input  logic [XLEN-1:0] RD1_E,
   input  logic [XLEN-1:0] RD2_E,
   input  logic [XLEN-1:0] Imm_Ext_E,
   input  logic [4:0]      RD_E,
   input  logic [XLEN-1:0] PC_E,
   input  logic [XLEN-1:0] PCPlus4_E,
   input  logic [1:0]      ForwardA_E,
   input  logic [1:0]      ForwardB_E,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrc_E,
   output logic [XLEN-1:0] PCTarget_E,
   output logic            RegWrite_M,
   output logic            MemWrite_M,
   output logic [1:0]      ResultSrc_M,
   output logic [4:0]      RD_M,
   output logic [XLEN-1:0] ALUResult_M,
   output logic [XLEN-1:0] WriteData_M,
   output logic [XLEN-1:0] PCPlus4_M
);

   logic            regwrite_q, memwrite_q;
   logic [1:0]      resultsrc_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] alu_result_q, write_data_q, pcplus4_q;

   logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result_d;
   logic            zero, cond;

   // Forward select 11 is unused by the hazard unit and falls back to the register operand.
   always_comb begin
      case (ForwardA_E)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = alu_result_q;
         default: src_a = RD1_E;
      endcase
      case (ForwardB_E)
         2'b01:   fwd_b = ResultW;
         2'b10:   fwd_b = alu_result_q;
         default: fwd_b = RD2_E;
      endcase
   end

   assign src_b = ALUSrc_E ? Imm_Ext_E : fwd_b;

   always_comb begin
      case (ALUControl_E)
         3'b000:  alu_result_d = src_a + src_b;
         3'b001:  alu_result_d = src_a - src_b;
         3'b010:  alu_result_d = src_a & src_b;
         3'b011:  alu_result_d = src_a | src_b;
         3'b100:  alu_result_d = src_a ^ src_b;
         3'b101:  alu_result_d = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         3'b110:  alu_result_d = {{(XLEN-1){1'b0}}, src_a < src_b};
         default: alu_result_d = src_a << src_b[4:0];
      endcase
   end

   assign zero = (alu_result_d == '0);

   // Extended compares look at the forwarded operands, not the ALU result.
   always_comb begin
      case (funct3_E)
         3'b000:  cond = zero;
         3'b001:  cond = !zero;
`ifdef EXEC_BRANCH_EXT_EN
         3'b100:  cond = $signed(src_a) <  $signed(fwd_b);
         3'b101:  cond = $signed(src_a) >= $signed(fwd_b);
         3'b110:  cond = src_a <  fwd_b;
         3'b111:  cond = src_a >= fwd_b;
`endif
         default: cond = 1'b0;
      endcase
   end

   assign PCSrc_E    = Jump_E | (Branch_E & cond);
   assign PCTarget_E = PC_E + Imm_Ext_E;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regwrite_q   <= 1'b0;
         memwrite_q   <= 1'b0;
         resultsrc_q  <= 2'b00;
         rd_q         <= 5'd0;
         alu_result_q <= '0;
         write_data_q <= '0;
         pcplus4_q    <= '0;
      end else begin
         regwrite_q   <= RegWrite_E;
         memwrite_q   <= MemWrite_E;
         resultsrc_q  <= ResultSrc_E;
         rd_q         <= RD_E;
         alu_result_q <= alu_result_d;
         write_data_q <= fwd_b;
         pcplus4_q    <= PCPlus4_E;
      end
   end

   assign RegWrite_M  = regwrite_q;
   assign MemWrite_M  = memwrite_q;
   assign ResultSrc_M = resultsrc_q;
   assign RD_M        = rd_q;
   assign ALUResult_M = alu_result_q;
   assign WriteData_M = write_data_q;
   assign PCPlus4_M   = pcplus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: per-cycle reference model plus directed literal checks.
module tb_execute_cycle;

   logic        clk, rst;
   logic        RegWrite_E, ALUSrc_E, MemWrite_E, Branch_E, Jump_E;
   logic [1:0]  ResultSrc_E, ForwardA_E, ForwardB_E;
   logic [2:0]  ALUControl_E, funct3_E;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E, ResultW;
   logic [4:0]  RD_E;
   logic        PCSrc_E, RegWrite_M, MemWrite_M;
   logic [31:0] PCTarget_E, ALUResult_M, WriteData_M, PCPlus4_M;
   logic [1:0]  ResultSrc_M;
   logic [4:0]  RD_M;

   execute_cycle dut (
      .clk(clk), .rst(rst),
      .RegWrite_E(RegWrite_E), .ALUSrc_E(ALUSrc_E), .MemWrite_E(MemWrite_E),
      .Branch_E(Branch_E), .Jump_E(Jump_E), .ResultSrc_E(ResultSrc_E),
      .ALUControl_E(ALUControl_E), .funct3_E(funct3_E),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
      .PC_E(PC_E), .PCPlus4_E(PCPlus4_E),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
      .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
      .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
      .RD_M(RD_M), .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
      .PCPlus4_M(PCPlus4_M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: EX/MEM contents as the bench believes them to be.
   logic        m_rw, m_mw;
   logic [1:0]  m_rs;
   logic [4:0]  m_rd;
   logic [31:0] m_alu, m_wd, m_pc4;

   task automatic model_eval(output logic pcsrc, output logic [31:0] tgt,
                             output logic [31:0] alu, output logic [31:0] wd);
      logic [31:0] a, b, sb;
      logic        c;
      a  = (ForwardA_E == 2'd1) ? ResultW : (ForwardA_E == 2'd2) ? m_alu : RD1_E;
      b  = (ForwardB_E == 2'd1) ? ResultW : (ForwardB_E == 2'd2) ? m_alu : RD2_E;
      sb = ALUSrc_E ? Imm_Ext_E : b;
      case (ALUControl_E)
         3'd0: alu = a + sb;
         3'd1: alu = a - sb;
         3'd2: alu = a & sb;
         3'd3: alu = a | sb;
         3'd4: alu = a ^ sb;
         3'd5: alu = (int'(a) < int'(sb)) ? 32'd1 : 32'd0;
         3'd6: alu = (a < sb) ? 32'd1 : 32'd0;
         default: alu = a << (sb % 32);
      endcase
      c = 1'b0;
      if (funct3_E == 3'd0) c = (alu == 0);
      if (funct3_E == 3'd1) c = (alu != 0);
`ifdef EXEC_BRANCH_EXT_EN
      if (funct3_E == 3'd4) c = int'(a) <  int'(b);
      if (funct3_E == 3'd5) c = int'(a) >= int'(b);
      if (funct3_E == 3'd6) c = a <  b;
      if (funct3_E == 3'd7) c = a >= b;
`endif
      pcsrc = Jump_E | (Branch_E & c);
      tgt   = PC_E + Imm_Ext_E;
      wd    = b;
   endtask

   always @(posedge clk or negedge rst) begin
      logic p; logic [31:0] t, al, w;
      if (!rst) begin
         m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
      end else begin
         model_eval(p, t, al, w);
         m_rw = RegWrite_E; m_mw = MemWrite_E; m_rs = ResultSrc_E; m_rd = RD_E;
         m_alu = al; m_wd = w; m_pc4 = PCPlus4_E;
      end
   end

   always @(negedge clk) begin
      logic p; logic [31:0] t, al, w;
      if (chk_en) begin
         model_eval(p, t, al, w);
         chk("PCSrc_E", {31'd0, PCSrc_E}, {31'd0, p});
         chk("PCTarget_E", PCTarget_E, t);
         chk("RegWrite_M", {31'd0, RegWrite_M}, {31'd0, m_rw});
         chk("MemWrite_M", {31'd0, MemWrite_M}, {31'd0, m_mw});
         chk("ResultSrc_M", {30'd0, ResultSrc_M}, {30'd0, m_rs});
         chk("RD_M", {27'd0, RD_M}, {27'd0, m_rd});
         chk("ALUResult_M", ALUResult_M, m_alu);
         chk("WriteData_M", WriteData_M, m_wd);
         chk("PCPlus4_M", PCPlus4_M, m_pc4);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      RegWrite_E = 0; ALUSrc_E = 0; MemWrite_E = 0; Branch_E = 0; Jump_E = 0;
      ResultSrc_E = 0; ALUControl_E = 0; funct3_E = 0; RD1_E = 0; RD2_E = 0;
      Imm_Ext_E = 0; RD_E = 0; PC_E = 0; PCPlus4_E = 0;
      ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
   endtask

   logic [31:0] sweep_exp [7];

   initial begin
      sweep_exp[0] = 32'h0000_0000; sweep_exp[1] = 32'hFFFF_FFFE;
      sweep_exp[2] = 32'h0000_0001; sweep_exp[3] = 32'hFFFF_FFFF;
      sweep_exp[4] = 32'hFFFF_FFFE; sweep_exp[5] = 32'h0000_0001;
      sweep_exp[6] = 32'h0000_0000;
      clr();
      rst = 1'b1;
      #1 rst = 1'b0;
      chk_en = 1'b1;
      // Reset with arbitrary inputs
      RegWrite_E = 1; MemWrite_E = 1; ResultSrc_E = 2'd3; RD_E = 5'd9;
      RD1_E = 32'h1234_5678; RD2_E = 32'h0F0F_0F0F; PC_E = 32'h200; Imm_Ext_E = 32'h10;
      PCPlus4_E = 32'h204; Jump_E = 1;
      tick(); tick();
      chk("rst_ALUResult_M", ALUResult_M, 32'h0);
      chk("rst_RegWrite_M", {31'd0, RegWrite_M}, 32'h0);
      chk("rst_PCTarget_E", PCTarget_E, 32'h210);
      chk("rst_PCSrc_E", {31'd0, PCSrc_E}, 32'h1);
      // Release, ADD 5+7
      clr();
      RegWrite_E = 1; RD1_E = 5; RD2_E = 7; RD_E = 5'd3;
      rst = 1'b1;
      #2 chk("post_rst_RegWrite_M", {31'd0, RegWrite_M}, 32'h0);
      tick();
      chk("add_ALUResult_M", ALUResult_M, 32'd12);
      chk("add_RD_M", {27'd0, RD_M}, 32'd3);
      // Forwarding: ADDI 0xC+4, then forward from M
      RD1_E = 32'hC; Imm_Ext_E = 4; ALUSrc_E = 1;
      tick();
      chk("addi_ALUResult_M", ALUResult_M, 32'h10);
      ForwardA_E = 2'b10; RD1_E = 0; Imm_Ext_E = 4; ALUSrc_E = 1;
      ForwardB_E = 2'b01; ResultW = 32'hAB; RD2_E = 32'h55;
      tick();
      chk("fwdA_ALUResult_M", ALUResult_M, 32'h14);
      chk("fwdB_WriteData_M", WriteData_M, 32'hAB);
      // Forward select 11 behaves as 00
      ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 32'h100; RD2_E = 32'h22; ALUSrc_E = 0;
      tick();
      chk("fwd11_ALUResult_M", ALUResult_M, 32'h122);
      chk("fwd11_WriteData_M", WriteData_M, 32'h22);
      // ALU sweep
      clr();
      RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
      for (int op = 0; op < 7; op++) begin
         ALUControl_E = 3'(op);
         tick();
         chk($sformatf("alu_op%0d", op), ALUResult_M, sweep_exp[op]);
      end
      ALUControl_E = 3'd7; RD2_E = 32'h21;
      tick();
      chk("alu_sll", ALUResult_M, 32'hFFFF_FFFE);
      // Branch BEQ/BNE
      clr();
      Branch_E = 1; ALUControl_E = 3'd1; RD1_E = 9; RD2_E = 9;
      PC_E = 32'h100; Imm_Ext_E = 32'hFFFF_FFF8;
      #1 chk("beq_PCSrc_E", {31'd0, PCSrc_E}, 32'h1);
      chk("beq_PCTarget_E", PCTarget_E, 32'hF8);
      funct3_E = 3'd1;
      #1 chk("bne_PCSrc_E", {31'd0, PCSrc_E}, 32'h0);
      tick();
      // JAL
      clr();
      Jump_E = 1; PC_E = 32'h40; Imm_Ext_E = 32'h20; PCPlus4_E = 32'h44;
      ResultSrc_E = 2'b10; RegWrite_E = 1; RD_E = 5'd1;
      #1 chk("jal_PCSrc_E", {31'd0, PCSrc_E}, 32'h1);
      chk("jal_PCTarget_E", PCTarget_E, 32'h60);
      tick();
      chk("jal_PCPlus4_M", PCPlus4_M, 32'h44);
      chk("jal_ResultSrc_M", {30'd0, ResultSrc_M}, 32'h2);
      // Extended branches
      clr();
      Branch_E = 1; ALUControl_E = 3'd1; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
      for (int f = 2; f < 8; f++) begin
         logic exp_t;
         funct3_E = 3'(f);
         exp_t = 1'b0;
`ifdef EXEC_BRANCH_EXT_EN
         exp_t = (f == 4) || (f == 7);
`endif
         #1 chk($sformatf("br_f3_%0d", f), {31'd0, PCSrc_E}, {31'd0, exp_t});
         tick();
      end
      // Mid-instruction reset drops EX/MEM contents
      clr();
      RegWrite_E = 1; MemWrite_E = 1; RD1_E = 32'h77; RD_E = 5'd4;
      tick();
      chk("pre_rst_ALUResult_M", ALUResult_M, 32'h77);
      rst = 1'b0;
      #1 chk("mid_rst_ALUResult_M", ALUResult_M, 32'h0);
      chk("mid_rst_MemWrite_M", {31'd0, MemWrite_M}, 32'h0);
      tick();
      rst = 1'b1;
      // Flushed bubble
      clr();
      tick();
      chk("bubble_RegWrite_M", {31'd0, RegWrite_M}, 32'h0);
      tick();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
